rob_retire: RTL and testbench

- In-order reorder buffer: the retire-side counterpart of the register rename stage.
- Each renamed instruction is allocated an entry holding its destination arch reg, new physical reg and the previous physical mapping of that arch reg.
- Writeback marks entries complete.
- Entries retire strictly in program order, one per cycle. On retire the block returns the superseded physical register to the rename free list via retire_valid/retire_phys_reg.

---
 rtl/rob_retire.sv | 129 ++++++++++++
 tb/tb_rob_retire.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rob_retire.sv
// rob_retire: in-order reorder buffer that retires one complete entry per cycle and frees the superseded physical register.
// Optional flush port enabled by defining ROB_FLUSH_EN.
module rob_retire #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int PHYS_W = 6,
  parameter int ARCH_W = 5,
  parameter logic [PHYS_W-1:0] INVALID_PHYS = 6'h3F
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              alloc_valid,
  input  logic              alloc_has_rd,
  input  logic [ARCH_W-1:0] alloc_rd,
  input  logic [PHYS_W-1:0] alloc_phys_rd,
  input  logic [PHYS_W-1:0] alloc_old_phys,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  output logic              retire_valid,
  output logic [PHYS_W-1:0] retire_phys_reg,
  output logic [ARCH_W-1:0] retire_arch_rd,
  output logic              inst_retired,
  output logic [TAG_W:0]    rob_count,
  output logic              rob_empty,
  output logic              rob_full
);
  logic flush_w;
`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif
  logic [ROB_DEPTH-1:0]             valid_q, valid_d, complete_q, complete_d, has_rd_q, has_rd_d;
  logic [ROB_DEPTH-1:0][ARCH_W-1:0] rd_q, rd_d;
  logic [ROB_DEPTH-1:0][PHYS_W-1:0] phys_q, phys_d, old_q, old_d;
  logic [TAG_W-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]                   count_q, count_d;
  logic                             retire_valid_q, retire_valid_d, inst_retired_q, inst_retired_d;
  logic [PHYS_W-1:0]                retire_phys_q, retire_phys_d;
  logic [ARCH_W-1:0]                retire_arch_q, retire_arch_d;
  logic                             do_retire, do_alloc, do_wb;
  // The new mapping is held in the entry for commit-side debug visibility only.
  logic unused_phys;
  assign unused_phys = ^phys_q;
  assign rob_count       = count_q;
  assign rob_empty       = count_q == '0;
  assign rob_full        = count_q == (TAG_W+1)'(ROB_DEPTH);
  assign alloc_ready     = !rob_full;
  assign alloc_tag       = tail_q;
  assign retire_valid    = retire_valid_q;
  assign inst_retired    = inst_retired_q;
  assign retire_phys_reg = retire_phys_q;
  assign retire_arch_rd  = retire_arch_q;
  always_comb begin
    do_retire      = valid_q[head_q] && complete_q[head_q] && !flush_w;
    do_alloc       = alloc_valid && !rob_full && !flush_w;
    do_wb          = wb_valid && valid_q[wb_tag] && !flush_w;
    valid_d        = valid_q;
    complete_d     = complete_q;
    has_rd_d       = has_rd_q;
    rd_d           = rd_q;
    phys_d         = phys_q;
    old_d          = old_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_retire);
    retire_valid_d = do_retire && has_rd_q[head_q] && old_q[head_q] != INVALID_PHYS;
    inst_retired_d = do_retire;
    retire_phys_d  = do_retire ? old_q[head_q] : INVALID_PHYS;
    retire_arch_d  = do_retire ? rd_q[head_q] : '0;
    if (do_wb) complete_d[wb_tag] = 1'b1;
    if (do_retire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + TAG_W'(1);
    end
    if (do_alloc) begin
      valid_d[tail_q]    = 1'b1;
      complete_d[tail_q] = 1'b0;
      has_rd_d[tail_q]   = alloc_has_rd;
      rd_d[tail_q]       = alloc_rd;
      phys_d[tail_q]     = alloc_phys_rd;
      old_d[tail_q]      = alloc_old_phys;
      tail_d             = tail_q + TAG_W'(1);
    end
    if (flush_w) begin
      valid_d    = '0;
      complete_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q        <= '0;
      complete_q     <= '0;
      has_rd_q       <= '0;
      rd_q           <= '0;
      phys_q         <= '0;
      old_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
      inst_retired_q <= 1'b0;
      retire_phys_q  <= INVALID_PHYS;
      retire_arch_q  <= '0;
    end else begin
      valid_q        <= valid_d;
      complete_q     <= complete_d;
      has_rd_q       <= has_rd_d;
      rd_q           <= rd_d;
      phys_q         <= phys_d;
      old_q          <= old_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      retire_valid_q <= retire_valid_d;
      inst_retired_q <= inst_retired_d;
      retire_phys_q  <= retire_phys_d;
      retire_arch_q  <= retire_arch_d;
    end
  end
endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: directed stimulus checked every cycle against a queue-based program-order model, plus literal spot checks.
module tb_rob_retire;
  logic       clk = 0, reset_n = 0, flush = 0;
  logic       alloc_valid = 0, alloc_has_rd = 0, wb_valid = 0;
  logic [4:0] alloc_rd = 0;
  logic [5:0] alloc_phys_rd = 0, alloc_old_phys = 0;
  logic [3:0] wb_tag = 0;
  logic       alloc_ready, retire_valid, inst_retired, rob_empty, rob_full;
  logic [3:0] alloc_tag;
  logic [5:0] retire_phys_reg;
  logic [4:0] retire_arch_rd;
  logic [4:0] rob_count;
  int n_cmp = 0, n_err = 0;

  rob_retire dut (
    .clk(clk), .reset_n(reset_n),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd),
    .alloc_phys_rd(alloc_phys_rd), .alloc_old_phys(alloc_old_phys),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .retire_valid(retire_valid), .retire_phys_reg(retire_phys_reg),
    .retire_arch_rd(retire_arch_rd), .inst_retired(inst_retired),
    .rob_count(rob_count), .rob_empty(rob_empty), .rob_full(rob_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the ROB is a program-order queue; tags are positions counted from the head tag.
  typedef struct {logic has_rd; logic [4:0] rd; logic [5:0] old; bit done;} ent_t;
  ent_t q[$];
  ent_t ne;
  int   mhead = 0, mtail = 0, wi;
  bit   m_ret, m_aok;
  logic e_rv = 0, e_ir = 0;
  logic [5:0] e_phys = 6'h3F;
  logic [4:0] e_arch = 0;

  always @(posedge clk) begin
    if (!reset_n || flush) begin
      q.delete(); mhead = 0; mtail = 0;
      e_rv = 0; e_ir = 0; e_phys = 6'h3F; e_arch = 0;
    end else begin
      m_ret = q.size() > 0 && q[0].done;
      m_aok = q.size() < 16;
      e_ir = m_ret; e_rv = 0; e_phys = 6'h3F; e_arch = 0;
      if (m_ret) begin
        e_rv = q[0].has_rd && q[0].old != 6'h3F;
        e_phys = q[0].old;
        e_arch = q[0].rd;
      end
      wi = (int'(wb_tag) - mhead + 16) % 16;
      if (wb_valid && wi < q.size()) q[wi].done = 1;
      if (m_ret) begin
        void'(q.pop_front());
        mhead = (mhead + 1) % 16;
      end
      if (alloc_valid && m_aok) begin
        ne.has_rd = alloc_has_rd; ne.rd = alloc_rd; ne.old = alloc_old_phys; ne.done = 0;
        q.push_back(ne);
        mtail = (mtail + 1) % 16;
      end
    end
    #1;
    chk("count", rob_count, q.size());
    chk("empty", rob_empty, q.size() == 0);
    chk("full", rob_full, q.size() == 16);
    chk("ready", alloc_ready, q.size() != 16);
    chk("tag", alloc_tag, mtail);
    chk("retire_valid", retire_valid, e_rv);
    chk("inst_retired", inst_retired, e_ir);
    chk("retire_phys", retire_phys_reg, e_phys);
    if (e_ir) chk("retire_arch", retire_arch_rd, e_arch);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic alloc1(input logic hr, input logic [4:0] rd, input logic [5:0] ph, input logic [5:0] old);
    alloc_valid = 1; alloc_has_rd = hr; alloc_rd = rd; alloc_phys_rd = ph; alloc_old_phys = old;
    cyc();
    alloc_valid = 0;
  endtask

  task automatic wb1(input logic [3:0] t);
    wb_valid = 1; wb_tag = t;
    cyc();
    wb_valid = 0;
  endtask

  task automatic do_reset();
    reset_n = 0; alloc_valid = 0; wb_valid = 0; flush = 0;
    cyc(); cyc();
    reset_n = 1;
  endtask

  initial begin
    do_reset();
    chk("rst_empty", rob_empty, 1);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_phys", retire_phys_reg, 6'h3F);
    chk("rst_tag", alloc_tag, 0);
    // Three entries retire in order on consecutive cycles
    alloc1(1, 1, 32, 1); alloc1(1, 2, 33, 2); alloc1(1, 3, 34, 3);
    chk("t1_count", rob_count, 3);
    wb_valid = 1; wb_tag = 0; cyc();
    chk("t1_no_early", inst_retired, 0);
    wb_tag = 1; cyc();
    chk("t1_rv0", retire_valid, 1); chk("t1_ph0", retire_phys_reg, 1); chk("t1_rd0", retire_arch_rd, 1);
    wb_tag = 2; cyc();
    chk("t1_rv1", retire_valid, 1); chk("t1_ph1", retire_phys_reg, 2); chk("t1_rd1", retire_arch_rd, 2);
    wb_valid = 0; cyc();
    chk("t1_rv2", retire_valid, 1); chk("t1_ph2", retire_phys_reg, 3); chk("t1_rd2", retire_arch_rd, 3);
    cyc();
    chk("t1_idle", retire_valid, 0); chk("t1_empty", rob_empty, 1);
    // Younger complete entry waits for older incomplete one
    do_reset();
    alloc1(1, 4, 40, 10); alloc1(1, 5, 41, 11);
    wb1(1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_blocked", inst_retired, 0);
      cyc();
    end
    wb1(0);
    cyc();
    chk("t2_ph0", retire_phys_reg, 10);
    cyc();
    chk("t2_ph1", retire_phys_reg, 11);
    // Fill, drop overflow alloc, retire one, wrap tail
    do_reset();
    for (int i = 0; i < 16; i++) alloc1(1, 5'(i), 6'(32 + i), 6'(i + 1));
    chk("t3_full", rob_full, 1); chk("t3_ready", alloc_ready, 0);
    chk("t3_count", rob_count, 16); chk("t3_tag", alloc_tag, 0);
    alloc1(1, 9, 9, 9);
    chk("t3_drop_count", rob_count, 16); chk("t3_drop_tag", alloc_tag, 0);
    wb1(0);
    cyc();
    chk("t3_ret_ph", retire_phys_reg, 1); chk("t3_ready2", alloc_ready, 1); chk("t3_count2", rob_count, 15);
    alloc1(1, 7, 50, 20);
    chk("t3_wrap_tag", alloc_tag, 1); chk("t3_count3", rob_count, 16);
    // No-rd and invalid old mapping retire without freeing
    do_reset();
    alloc1(0, 7, 36, 5); alloc1(1, 8, 37, 6'h3F);
    wb_valid = 1; wb_tag = 0; cyc();
    wb_tag = 1; cyc();
    chk("t4_ir_a", inst_retired, 1); chk("t4_rv_a", retire_valid, 0); chk("t4_rd_a", retire_arch_rd, 7);
    wb_valid = 0; cyc();
    chk("t4_ir_b", inst_retired, 1); chk("t4_rv_b", retire_valid, 0); chk("t4_rd_b", retire_arch_rd, 8);
    // Allocate and retire in one cycle at count 8, then reset mid-stream
    do_reset();
    for (int i = 0; i < 8; i++) alloc1(1, 5'(i + 1), 6'(40 + i), 6'(i + 1));
    wb1(0);
    chk("t5_count8", rob_count, 8);
    alloc1(1, 20, 60, 30);
    chk("t5_same_count", rob_count, 8); chk("t5_same_ir", inst_retired, 1);
    wb1(1);
    cyc();
    chk("t5_pulse", retire_valid, 1);
    reset_n = 0;
    #1;
    chk("t5_rst_count", rob_count, 0); chk("t5_rst_rv", retire_valid, 0);
    chk("t5_rst_ir", inst_retired, 0); chk("t5_rst_ph", retire_phys_reg, 6'h3F);
    chk("t5_rst_empty", rob_empty, 1);
    cyc(); cyc();
    reset_n = 1;
    cyc(); cyc();
    chk("t5_after", inst_retired, 0);
`ifdef ROB_FLUSH_EN
    do_reset();
    for (int i = 0; i < 4; i++) alloc1(1, 5'(i + 1), 6'(40 + i), 6'(i + 1));
    wb1(2); wb1(3);
    flush = 1; cyc(); flush = 0;
    chk("fl_count", rob_count, 0); chk("fl_tag", alloc_tag, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("fl_no_rv", retire_valid, 0);
    end
    alloc1(1, 1, 33, 2);
    chk("fl_tag1", alloc_tag, 1); chk("fl_count1", rob_count, 1);
`endif
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
